// File: rtl/brick_draw.sv
// Brick rasteriser: latches one brick on start, then emits one VGA pixel write
// per clock in raster order, with health-based colour and a 1-pixel mortar gap.
module brick_draw #(
  parameter int         BRICK_W  = 10,
  parameter int         BRICK_H  = 5,
  parameter int         SCREEN_W = 160,
  parameter int         SCREEN_H = 120,
  parameter logic [2:0] COL_BG   = 3'b000,
  parameter logic [2:0] COL_H1   = 3'b010,
  parameter logic [2:0] COL_H2   = 3'b110,
  parameter logic [2:0] COL_H3   = 3'b100
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [9:0] x_in,
  input  logic [9:0] y_in,
  input  logic [1:0] health_in,
  output logic [9:0] vga_x,
  output logic [9:0] vga_y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

  localparam logic [5:0]  PX_LAST = 6'(BRICK_W - 1);
  localparam logic [5:0]  PY_LAST = 6'(BRICK_H - 1);
  localparam logic [10:0] SW      = 11'(SCREEN_W);
  localparam logic [10:0] SH      = 11'(SCREEN_H);

  state_t     state_q, state_d;
  logic [5:0] px_q, px_d, py_q, py_d;
  logic [9:0] x_l_q, x_l_d, y_l_q, y_l_d;
  logic [1:0] h_l_q, h_l_d;
  logic [9:0] vga_x_q, vga_x_d, vga_y_q, vga_y_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d, busy_q, busy_d, done_q, done_d;

  logic [9:0] sx, sy;
  logic [2:0] hcol;
  logic       gap;

  // Sums wrap modulo 1024; clipped pixels still take their cycle.
  assign sx  = x_l_q + 10'(px_q);
  assign sy  = y_l_q + 10'(py_q);
  assign gap = (px_q == PX_LAST) || (py_q == PY_LAST);

  always_comb begin
    unique case (h_l_q)
      2'd1:    hcol = COL_H1;
      2'd2:    hcol = COL_H2;
      2'd3:    hcol = COL_H3;
      default: hcol = COL_BG;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    px_d     = px_q;
    py_d     = py_q;
    x_l_d    = x_l_q;
    y_l_d    = y_l_q;
    h_l_d    = h_l_q;
    vga_x_d  = vga_x_q;
    vga_y_d  = vga_y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          x_l_d   = x_in;
          y_l_d   = y_in;
          h_l_d   = health_in;
          px_d    = '0;
          py_d    = '0;
          busy_d  = 1'b1;
          state_d = S_DRAW;
        end
      end
      S_DRAW: begin
        vga_x_d  = sx;
        vga_y_d  = sy;
        colour_d = gap ? COL_BG : hcol;
        plot_d   = ({1'b0, sx} < SW) && ({1'b0, sy} < SH);
        if (px_q == PX_LAST) begin
          px_d = '0;
          if (py_q == PY_LAST) begin
            py_d    = '0;
            state_d = S_DONE;
          end else begin
            py_d = py_q + 6'd1;
          end
        end else begin
          px_d = px_q + 6'd1;
        end
      end
      S_DONE: begin
        // Return straight to IDLE so a start on the next edge is accepted.
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q  <= S_IDLE;
      px_q     <= '0;
      py_q     <= '0;
      x_l_q    <= '0;
      y_l_q    <= '0;
      h_l_q    <= '0;
      vga_x_q  <= '0;
      vga_y_q  <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      px_q     <= px_d;
      py_q     <= py_d;
      x_l_q    <= x_l_d;
      y_l_q    <= y_l_d;
      h_l_q    <= h_l_d;
      vga_x_q  <= vga_x_d;
      vga_y_q  <= vga_y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign vga_x  = vga_x_q;
  assign vga_y  = vga_y_q;
  assign colour = colour_q;
  assign plot   = plot_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_brick_draw.sv
// Bench for brick_draw: directed cases plus random bricks against a
// rectangle-level reference model.
module tb_brick_draw;
  localparam int BW = 10;
  localparam int BH = 5;
  localparam int SW = 160;
  localparam int SH = 120;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       start = 1'b0;
  logic [9:0] x_in = '0;
  logic [9:0] y_in = '0;
  logic [1:0] health_in = '0;
  logic [9:0] vga_x, vga_y;
  logic [2:0] colour;
  logic       plot, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  brick_draw dut (
    .clk(clk), .resetn(resetn), .start(start),
    .x_in(x_in), .y_in(y_in), .health_in(health_in),
    .vga_x(vga_x), .vga_y(vga_y), .colour(colour),
    .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_col(int h, int px, int py);
    if (px == BW - 1 || py == BH - 1) return 0;
    case (h)
      1:       return 3'b010;
      2:       return 3'b110;
      3:       return 3'b100;
      default: return 0;
    endcase
  endfunction

  // One brick: accept on the next edge, then check every pixel, done and idle.
  task automatic draw_rect(input int x, input int y, input int h, input bit hold, input bit disturb);
    int ex, ey, idx;
    start = 1'b1; x_in = 10'(x); y_in = 10'(y); health_in = 2'(h);
    @(negedge clk);
    chk("acc_busy", busy, 1); chk("acc_plot", plot, 0); chk("acc_done", done, 0);
    if (!hold) start = 1'b0;
    ex = 0; ey = 0; idx = 0;
    for (int py = 0; py < BH; py++) begin
      for (int px = 0; px < BW; px++) begin
        @(negedge clk);
        ex = (x + px) % 1024;
        ey = (y + py) % 1024;
        chk("pix_x", vga_x, ex);
        chk("pix_y", vga_y, ey);
        chk("pix_col", colour, exp_col(h, px, py));
        chk("pix_plot", plot, (ex < SW && ey < SH) ? 1 : 0);
        chk("pix_busy", busy, 1);
        chk("pix_done", done, 0);
        if (disturb && idx == 20) begin
          start = 1'b1; x_in = ~x_in; y_in = y_in + 10'd3; health_in = health_in + 2'd1;
        end
        if (disturb && idx == 21) start = 1'b0;
        idx++;
      end
    end
    @(negedge clk);
    chk("done_hi", done, 1); chk("done_plot", plot, 0); chk("done_busy", busy, 1);
    chk("hold_x", vga_x, ex); chk("hold_y", vga_y, ey);
    if (!hold) begin
      @(negedge clk);
      chk("idle_done", done, 0); chk("idle_busy", busy, 0); chk("idle_plot", plot, 0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_x", vga_x, 0); chk("rst_y", vga_y, 0); chk("rst_col", colour, 0);
    chk("rst_plot", plot, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    resetn = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", busy, 0); chk("post_rst_plot", plot, 0);

    draw_rect(20, 10, 1, 0, 0);
    draw_rect(0, 0, 0, 0, 0);
    draw_rect(10, 5, 2, 0, 0);
    draw_rect(10, 5, 3, 0, 0);
    draw_rect(155, 118, 1, 0, 0);
    draw_rect(40, 40, 2, 0, 1);

    // Asynchronous reset at pixel 30.
    start = 1'b1; x_in = 10'd20; y_in = 10'd10; health_in = 2'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    chk("pre_abort_plot", plot, 1);
    #1 resetn = 1'b1;
    #1;
    chk("abort_plot", plot, 0); chk("abort_busy", busy, 0); chk("abort_done", done, 0);
    @(negedge clk);
    resetn = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      chk("abort_nodone", done, 0);
    end
    draw_rect(20, 10, 1, 0, 0);

    // Start held high: back-to-back bricks every BW*BH+2 cycles.
    for (int r = 0; r < 4; r++) draw_rect(30, 20, r, (r < 3), 0);

    for (int i = 0; i < 20; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        chk("gap_plot", plot, 0); chk("gap_busy", busy, 0);
      end
      if (i < 10)
        draw_rect($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 3), 0, 0);
      else
        draw_rect($urandom_range(140, 170), $urandom_range(100, 130), $urandom_range(0, 3), 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/brick_draw.md
Name: brick_draw

Overview:
- Pixel rasteriser directly downstream of the level loader.
- On a one-cycle start pulse (the loader's draw strobe), latches one brick's top-left coordinate and health, then emits one VGA pixel write per clock covering the brick rectangle.
- Pixel colour is selected from health; health 0 paints the background (erase).
- Outputs feed the VGA adapter's x/y/colour/plot inputs.
- Provides busy/done so the controller can check that the rectangle completes inside its fixed draw-delay window.

Parameters:
- BRICK_W, 10, brick width in pixels (1..64).
- BRICK_H, 5, brick height in pixels (1..64).
- SCREEN_W, 160, visible width; pixels at x >= SCREEN_W are clipped.
- SCREEN_H, 120, visible height; pixels at y >= SCREEN_H are clipped.
- COL_BG, 3'b000, colour for health 0 and for the gap pixels.
- COL_H1, 3'b010, colour for health 1.
- COL_H2, 3'b110, colour for health 2.
- COL_H3, 3'b100, colour for health 3.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous, active-high reset (port keeps the codebase name; polarity is high).
- start  input  1  draw request; sampled only in IDLE.
- x_in  input  10  brick top-left x.
- y_in  input  10  brick top-left y.
- health_in  input  2  brick health, 0..3.
- vga_x  output  10  pixel x.
- vga_y  output  10  pixel y.
- colour  output  3  pixel colour.
- plot  output  1  pixel write enable.
- busy  output  1  high from the accepting edge until done is issued.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (asynchronous, while resetn=1): state=IDLE; px=py=0; latched x, y and health all 0; vga_x=vga_y=0, colour=0, plot=0, busy=0, done=0. Reset mid-draw aborts immediately; no done pulse is issued.
- All outputs are registered.
- States:
  - IDLE: start=1 at edge k latches x_in, y_in and health_in, clears px and py, and moves to DRAW. busy=1 after edge k.
  - DRAW: each edge registers vga_x=x_l+px, vga_y=y_l+py, colour and plot, then advances px. When px=BRICK_W-1, px wraps to 0 and py increments. The edge that registers pixel (BRICK_W-1, BRICK_H-1) moves to DONE.
  - DONE: that edge sets done=1 and plot=0. The next edge returns to IDLE and clears done and busy.
- Timing: plot is high for exactly BRICK_W*BRICK_H cycles, after edges k+1 through k+BRICK_W*BRICK_H. done is high after edge k+BRICK_W*BRICK_H+1. The earliest next accepted start is at edge k+BRICK_W*BRICK_H+2.
- Budget: the loader's draw delay must be >= BRICK_W*BRICK_H+2.
- Pixel order: raster order, row-major, px fastest.
- Arithmetic: x_l+px and y_l+py are 10-bit and wrap modulo 1024 with no saturation.
- Clipping: a pixel with sum x >= SCREEN_W or sum y >= SCREEN_H is registered with plot=0 but still consumes its cycle, so timing is data-independent.
- Gap: pixels with px=BRICK_W-1 or py=BRICK_H-1 use COL_BG regardless of health (1-pixel mortar between bricks). All other pixels use the health colour map.
- start while busy (DRAW or DONE) is ignored; no queuing.
- start held high continuously is accepted again on the first IDLE edge after DONE.
- Input changes on x_in, y_in and health_in after acceptance have no effect.
- Outside DRAW, vga_x, vga_y and colour hold their last values and plot=0.

Test Plan:
- Reset then start with x=20, y=10, health=1 → 50 plot cycles starting the cycle after acceptance; first pixel (20,10) COL_H1; pixel (29,10) COL_BG; pixel (21,14) COL_BG; last pixel (29,14); done one cycle later; busy low on the following cycle.
- health=0 at (0,0) → all 50 pixels COL_BG with plot=1; health 2 and 3 at (10,5) → interior pixels COL_H2 and COL_H3 respectively.
- x=155, y=118 → cycle count unchanged at 50; plot=0 for every pixel with x>=160 or y>=120; plot=1 only at x 155..159, y 118..119.
- Second start pulse at cycle 20 of a draw, plus x_in/y_in changed mid-draw → ignored; only one rectangle drawn, using the originally latched values.
- Assert resetn asynchronously at pixel 30 → plot, busy and done drop to 0 without waiting for a clock edge; no done pulse; a start after release draws a full 50-pixel rectangle.
- start held high for 200 cycles → back-to-back rectangles every 52 cycles, each with exactly one done pulse.
